// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake engine: direction and FSM encodings,
// default palette and the cell-coordinate width helper.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DEAD   = 3'd4
    } state_e;

    localparam logic [2:0] DEF_BG_RGB   = 3'b101;
    localparam logic [2:0] DEF_WALL_RGB = 3'b010;
    localparam logic [2:0] DEF_BODY_RGB = 3'b110;
    localparam logic [2:0] DEF_HEAD_RGB = 3'b100;

    // Bits needed to hold a coordinate in [0, n-1]; never narrower than one bit.
    function automatic int unsigned cell_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic dir_e dir_reverse(input dir_e d);
        dir_e r;
        case (d)
            DIR_UP:   r = DIR_DOWN;
            DIR_DOWN: r = DIR_UP;
            DIR_LEFT: r = DIR_RIGHT;
            default:  r = DIR_LEFT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_field_renderer_occupancy.sv
// Cell-occupancy bitmap: two combinational read ports, one set and one clear
// write port (set wins on the same cell), synchronous reset to the start body.
module snake_occupancy_map
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W   = 40,
    parameter int unsigned GRID_H   = 30,
    parameter int unsigned INIT_LEN = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [cell_w(GRID_W)-1:0]   rd_x_i,
    input  logic [cell_w(GRID_H)-1:0]   rd_y_i,
    output logic                        rd_occ_o,
    input  logic [cell_w(GRID_W)-1:0]   chk_x_i,
    input  logic [cell_w(GRID_H)-1:0]   chk_y_i,
    output logic                        chk_occ_o,
    input  logic                        set_en_i,
    input  logic [cell_w(GRID_W)-1:0]   set_x_i,
    input  logic [cell_w(GRID_H)-1:0]   set_y_i,
    input  logic                        clr_en_i,
    input  logic [cell_w(GRID_W)-1:0]   clr_x_i,
    input  logic [cell_w(GRID_H)-1:0]   clr_y_i
);

    localparam int unsigned XW = cell_w(GRID_W);
    localparam int unsigned YW = cell_w(GRID_H);
    localparam int unsigned N  = GRID_W * GRID_H;
    localparam int unsigned IW = cell_w(N);

    function automatic logic [IW-1:0] cidx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return IW'(y) * IW'(GRID_W) + IW'(x);
    endfunction

    // Start body: INIT_LEN cells ending at the centre cell, extending left.
    function automatic logic [N-1:0] init_map();
        logic [N-1:0]  m;
        logic [IW-1:0] k;
        m = '0;
        for (int unsigned i = 0; i < INIT_LEN; i++) begin
            k    = IW'((GRID_H / 2) * GRID_W + GRID_W / 2 - i);
            m[k] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [N-1:0] INIT_MAP = init_map();

    logic [N-1:0]  occ_q, occ_d;
    logic [IW-1:0] set_idx, clr_idx;

    assign set_idx   = cidx(set_x_i, set_y_i);
    assign clr_idx   = cidx(clr_x_i, clr_y_i);
    assign rd_occ_o  = occ_q[cidx(rd_x_i, rd_y_i)];
    assign chk_occ_o = occ_q[cidx(chk_x_i, chk_y_i)];

    always_comb begin
        occ_d = occ_q;
        if (clr_en_i) occ_d[clr_idx] = 1'b0;
        if (set_en_i) occ_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) occ_q <= INIT_MAP;
        else       occ_q <= occ_d;
    end

endmodule

// File: rtl/snake_field_renderer.sv
// Grid snake engine: direction latch, move FSM, circular body buffer and a
// registered per-pixel colour lookup driven by the VGA pixel coordinates.
module snake_field_renderer
    import snake_pkg::*;
#(
    parameter int unsigned CELL_LOG2 = 4,
    parameter int unsigned GRID_W    = 40,
    parameter int unsigned GRID_H    = 30,
    parameter int unsigned MAX_LEN   = 64,
    parameter int unsigned INIT_LEN  = 3,
    parameter logic [2:0]  BG_RGB    = DEF_BG_RGB,
    parameter logic [2:0]  WALL_RGB  = DEF_WALL_RGB,
    parameter logic [2:0]  BODY_RGB  = DEF_BODY_RGB,
    parameter logic [2:0]  HEAD_RGB  = DEF_HEAD_RGB
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step,
    input  logic                         up,
    input  logic                         down,
    input  logic                         left,
    input  logic                         right,
    input  logic                         grow,
    input  logic [9:0]                   pix_x,
    input  logic [9:0]                   pix_y,
    input  logic                         video_on,
    output logic [2:0]                   rgb,
    output logic                         alive,
    output logic                         busy,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic [cell_w(GRID_W)-1:0]    head_x,
    output logic [cell_w(GRID_H)-1:0]    head_y
);

    localparam int unsigned XW = cell_w(GRID_W);
    localparam int unsigned YW = cell_w(GRID_H);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned PW = cell_w(MAX_LEN);

    localparam logic [XW-1:0] HOME_X = XW'(GRID_W / 2);
    localparam logic [YW-1:0] HOME_Y = YW'(GRID_H / 2);
    localparam logic [XW-1:0] EDGE_X = XW'(GRID_W - 1);
    localparam logic [YW-1:0] EDGE_Y = YW'(GRID_H - 1);

    state_e        state_q, state_d;
    dir_e          dir_q, dir_d, dir_req;
    logic          req_vld;
    logic          grow_q, grow_d;
    logic [XW-1:0] nx_q, nx_d, head_x_q, head_x_d;
    logic [YW-1:0] ny_q, ny_d, head_y_q, head_y_d;
    logic [LW-1:0] length_q, length_d;
    logic          alive_q, alive_d;
    logic [PW-1:0] hptr_q, hptr_d, tptr_q, tptr_d;
    logic [XW-1:0] buf_x_q [MAX_LEN];
    logic [YW-1:0] buf_y_q [MAX_LEN];
    logic          buf_we, set_en, clr_en;
    logic [XW-1:0] tail_x;
    logic [YW-1:0] tail_y;
    logic          chk_occ, rd_occ, grow_eff, nx_wall, hit_tail, collide;
    logic [9:0]    cell_x, cell_y;
    logic          in_grid, on_wall;
    logic [2:0]    rgb_q, rgb_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tail_x   = buf_x_q[tptr_q];
    assign tail_y   = buf_y_q[tptr_q];
    assign grow_eff = grow_q && (length_q < LW'(MAX_LEN));
    assign nx_wall  = (nx_q == '0) || (nx_q == EDGE_X) || (ny_q == '0) || (ny_q == EDGE_Y);
    assign hit_tail = (nx_q == tail_x) && (ny_q == tail_y);
    // The tail cell is vacated this move unless the snake is growing.
    assign collide  = nx_wall || (chk_occ && !(hit_tail && !grow_eff));

    always_comb begin
        req_vld = 1'b1;
        dir_req = dir_q;
        if (up)         dir_req = DIR_UP;
        else if (down)  dir_req = DIR_DOWN;
        else if (left)  dir_req = DIR_LEFT;
        else if (right) dir_req = DIR_RIGHT;
        else            req_vld = 1'b0;
        dir_d = dir_q;
        if (state_q == ST_IDLE && req_vld && dir_req != dir_reverse(dir_q)) dir_d = dir_req;
    end

    always_comb begin
        state_d  = state_q;
        grow_d   = grow_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        alive_d  = alive_q;
        length_d = length_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        hptr_d   = hptr_q;
        tptr_d   = tptr_q;
        buf_we   = 1'b0;
        set_en   = 1'b0;
        clr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (step) begin
                    grow_d  = grow;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                nx_d = head_x_q;
                ny_d = head_y_q;
                unique case (dir_q)
                    DIR_UP:    ny_d = head_y_q - 1'b1;
                    DIR_DOWN:  ny_d = head_y_q + 1'b1;
                    DIR_LEFT:  nx_d = head_x_q - 1'b1;
                    DIR_RIGHT: nx_d = head_x_q + 1'b1;
                    default:   nx_d = head_x_q;
                endcase
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (collide) begin
                    alive_d = 1'b0;
                    state_d = ST_DEAD;
                end else begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                hptr_d   = ptr_inc(hptr_q);
                buf_we   = 1'b1;
                set_en   = 1'b1;
                head_x_d = nx_q;
                head_y_d = ny_q;
                if (grow_eff) begin
                    length_d = length_q + 1'b1;
                end else begin
                    clr_en = 1'b1;
                    tptr_d = ptr_inc(tptr_q);
                end
                state_d = ST_IDLE;
            end
            ST_DEAD: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_RIGHT;
            grow_q   <= 1'b0;
            nx_q     <= HOME_X;
            ny_q     <= HOME_Y;
            head_x_q <= HOME_X;
            head_y_q <= HOME_Y;
            length_q <= LW'(INIT_LEN);
            alive_q  <= 1'b1;
            hptr_q   <= PW'(INIT_LEN - 1);
            tptr_q   <= '0;
            // Entry 0 holds the tail, entry INIT_LEN-1 the head.
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                buf_x_q[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2 - INIT_LEN + 1 + i) : '0;
                buf_y_q[i] <= HOME_Y;
            end
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            grow_q   <= grow_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            length_q <= length_d;
            alive_q  <= alive_d;
            hptr_q   <= hptr_d;
            tptr_q   <= tptr_d;
            if (buf_we) begin
                buf_x_q[hptr_d] <= nx_q;
                buf_y_q[hptr_d] <= ny_q;
            end
        end
    end

    snake_occupancy_map #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .INIT_LEN (INIT_LEN)
    ) u_occ (
        .clk_i     (clk),
        .rst_i     (reset),
        .rd_x_i    (XW'(cell_x)),
        .rd_y_i    (YW'(cell_y)),
        .rd_occ_o  (rd_occ),
        .chk_x_i   (nx_q),
        .chk_y_i   (ny_q),
        .chk_occ_o (chk_occ),
        .set_en_i  (set_en),
        .set_x_i   (nx_q),
        .set_y_i   (ny_q),
        .clr_en_i  (clr_en),
        .clr_x_i   (tail_x),
        .clr_y_i   (tail_y)
    );

    assign cell_x  = pix_x >> CELL_LOG2;
    assign cell_y  = pix_y >> CELL_LOG2;
    assign in_grid = (cell_x < 10'(GRID_W)) && (cell_y < 10'(GRID_H));
    assign on_wall = (cell_x == '0) || (cell_x == 10'(GRID_W - 1)) ||
                     (cell_y == '0) || (cell_y == 10'(GRID_H - 1));

    always_comb begin
        rgb_d = BG_RGB;
        if (!video_on)                                               rgb_d = 3'b000;
        else if (!in_grid)                                           rgb_d = BG_RGB;
        else if (on_wall)                                            rgb_d = WALL_RGB;
        else if (cell_x == 10'(head_x_q) && cell_y == 10'(head_y_q)) rgb_d = HEAD_RGB;
        else if (rd_occ)                                             rgb_d = BODY_RGB;
    end

    always_ff @(posedge clk) begin
        if (reset) rgb_q <= 3'b000;
        else       rgb_q <= rgb_d;
    end

    assign rgb    = rgb_q;
    assign alive  = alive_q;
    assign busy   = (state_q == ST_CALC) || (state_q == ST_CHECK) || (state_q == ST_UPDATE);
    assign length = length_q;
    assign head_x = head_x_q;
    assign head_y = head_y_q;

endmodule

// File: tb/tb_snake_field_renderer.sv
// Bench for snake_field_renderer: constant move table, hand corner-case
// sequences and random moves checked against a queue-based snake model.
module tb_snake_field_renderer;

    localparam int MAXL = 8;
    localparam logic [2:0] C_BG = 3'b101, C_WALL = 3'b010, C_BODY = 3'b110, C_HEAD = 3'b100;

    logic       clk = 1'b0;
    logic       reset, step, up, down, left, right, grow, video_on;
    logic [9:0] pix_x, pix_y;
    logic [2:0] rgb;
    logic       alive, busy;
    logic [3:0] length;
    logic [5:0] head_x;
    logic [4:0] head_y;

    int n_vec = 0;
    int n_err = 0;

    // Model: body queue tail..head, direction 0 up, 1 down, 2 left, 3 right.
    int q_x[$];
    int q_y[$];
    int m_dir;
    bit m_alive;

    typedef struct {
        bit u, d, l, r, g;
        int ex, ey, elen;
        bit ealive;
    } vec_t;
    vec_t tbl[8];

    snake_field_renderer #(
        .MAX_LEN (MAXL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .grow     (grow),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .video_on (video_on),
        .rgb      (rgb),
        .alive    (alive),
        .busy     (busy),
        .length   (length),
        .head_x   (head_x),
        .head_y   (head_y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_occ(input int x, input int y);
        foreach (q_x[i]) if (q_x[i] == x && q_y[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] m_colour(input int px, input int py, input bit von);
        int cx = px / 16;
        int cy = py / 16;
        if (!von) return 3'b000;
        if (cx >= 40 || cy >= 30) return C_BG;
        if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return C_WALL;
        if (cx == q_x[$] && cy == q_y[$]) return C_HEAD;
        if (m_occ(cx, cy)) return C_BODY;
        return C_BG;
    endfunction

    task automatic m_reset();
        q_x = {18, 19, 20};
        q_y = {15, 15, 15};
        m_dir = 3;
        m_alive = 1'b1;
    endtask

    task automatic m_move(input bit u, input bit d, input bit l, input bit r, input bit g);
        int req = -1;
        int nx, ny;
        bit geff, wall, hit;
        if (!m_alive) return;
        if (u)      req = 0;
        else if (d) req = 1;
        else if (l) req = 2;
        else if (r) req = 3;
        if (req >= 0 && req != (m_dir ^ 1)) m_dir = req;
        nx = q_x[$] + ((m_dir == 3) ? 1 : 0) - ((m_dir == 2) ? 1 : 0);
        ny = q_y[$] + ((m_dir == 1) ? 1 : 0) - ((m_dir == 0) ? 1 : 0);
        geff = g && (q_x.size() < MAXL);
        wall = (nx == 0 || nx == 39 || ny == 0 || ny == 29);
        hit  = m_occ(nx, ny) && !(nx == q_x[0] && ny == q_y[0] && !geff);
        if (wall || hit) begin
            m_alive = 1'b0;
        end else begin
            q_x.push_back(nx);
            q_y.push_back(ny);
            if (!geff) begin
                void'(q_x.pop_front());
                void'(q_y.pop_front());
            end
        end
    endtask

    task automatic do_move(input bit u, input bit d, input bit l, input bit r, input bit g);
        bit was = m_alive;
        up = u; down = d; left = l; right = r; grow = g; step = 1'b1;
        tick();
        step = 1'b0; grow = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        chk("busy_rise", busy, was);
        m_move(u, d, l, r, g);
        tick();
        tick();
        chk("alive", alive, m_alive);
        tick();
        chk("busy_fall", busy, 0);
        chk("head_x", head_x, q_x[$]);
        chk("head_y", head_y, q_y[$]);
        chk("length", length, q_x.size());
    endtask

    task automatic chk_pix(input int px, input int py, input bit von);
        pix_x = 10'(px); pix_y = 10'(py); video_on = von;
        tick();
        chk("rgb", rgb, m_colour(px, py, von));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        tbl[0] = '{0, 0, 0, 1, 0, 21, 15, 3, 1};
        tbl[1] = '{0, 0, 1, 0, 0, 22, 15, 3, 1};  // reverse ignored
        tbl[2] = '{1, 0, 1, 0, 0, 22, 14, 3, 1};  // up beats left
        tbl[3] = '{0, 0, 0, 0, 1, 22, 13, 4, 1};
        tbl[4] = '{0, 0, 1, 0, 0, 21, 13, 4, 1};
        tbl[5] = '{0, 1, 0, 1, 0, 21, 14, 4, 1};  // down beats right
        tbl[6] = '{0, 0, 0, 1, 0, 22, 14, 4, 1};  // tail chase
        tbl[7] = '{1, 0, 0, 0, 1, 22, 14, 4, 0};  // grow into tail kills

        {step, up, down, left, right, grow, video_on} = '0;
        pix_x = '0; pix_y = '0;
        reset = 1'b1;
        tick();
        tick();
        chk("rgb_reset", rgb, 0);
        chk("busy_reset", busy, 0);
        reset = 1'b0;
        m_reset();
        chk("len_reset", length, 3);
        chk("hx_reset", head_x, 20);
        chk("hy_reset", head_y, 15);
        chk("alive_reset", alive, 1);

        chk_pix(320, 240, 1);
        chk("head_pix", rgb, C_HEAD);
        chk_pix(0, 0, 1);
        chk("wall_pix", rgb, C_WALL);
        chk_pix(320, 240, 0);
        chk("blank_pix", rgb, 0);
        chk_pix(700, 100, 1);
        chk_pix(18 * 16 + 7, 15 * 16 + 9, 1);
        chk("tail_pix", rgb, C_BODY);

        for (int i = 0; i < 8; i++) begin
            do_move(tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].g);
            chk($sformatf("tbl%0d_hx", i), head_x, tbl[i].ex);
            chk($sformatf("tbl%0d_hy", i), head_y, tbl[i].ey);
            chk($sformatf("tbl%0d_len", i), length, tbl[i].elen);
            chk($sformatf("tbl%0d_alive", i), alive, tbl[i].ealive);
        end

        // Single step: old tail cell becomes background.
        do_reset();
        do_move(0, 0, 0, 1, 0);
        chk_pix(18 * 16 + 5, 15 * 16 + 5, 1);
        chk("old_tail_bg", rgb, C_BG);

        // Steps during a move are dropped.
        do_reset();
        right = 1'b1; step = 1'b1;
        tick();
        right = 1'b0;
        tick();
        tick();
        step = 1'b0;
        tick();
        chk("drop_hx", head_x, 21);
        for (int i = 0; i < 4; i++) tick();
        chk("drop_hx2", head_x, 21);
        chk("drop_busy", busy, 0);

        // Reset in the middle of a move.
        do_reset();
        right = 1'b1; step = 1'b1;
        tick();
        right = 1'b0; step = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_reset();
        chk("abort_hx", head_x, 20);
        chk("abort_len", length, 3);
        chk("abort_busy", busy, 0);
        chk_pix(21 * 16, 240, 1);
        chk("abort_pix", rgb, C_BG);

        // Grow to the cap, grow ignored at cap, then run into the right wall.
        do_reset();
        for (int i = 0; i < 5; i++) do_move(0, 0, 0, 1, 1);
        chk("cap_len", length, MAXL);
        do_move(0, 0, 0, 1, 1);
        chk("cap_len2", length, MAXL);
        chk("cap_hx", head_x, 26);
        for (int i = 0; i < 12; i++) do_move(0, 0, 0, 1, 0);
        chk("wall_hx", head_x, 38);
        chk_pix(31 * 16 + 2, 15 * 16 + 2, 1);
        chk("tail_after_wrap", rgb, C_BODY);
        do_move(0, 0, 0, 1, 0);
        chk("wall_dead", alive, 0);
        do_move(1, 0, 0, 0, 1);
        chk("dead_hx", head_x, 38);
        chk("dead_len", length, MAXL);

        // Self collision at length 5.
        do_reset();
        do_move(0, 0, 0, 1, 1);
        do_move(0, 0, 0, 1, 1);
        do_move(1, 0, 0, 0, 0);
        do_move(0, 0, 1, 0, 0);
        do_move(0, 1, 0, 0, 0);
        chk("self_dead", alive, 0);

        // Same loop at length 4 enters the vacated tail cell.
        do_reset();
        do_move(0, 0, 0, 1, 1);
        do_move(1, 0, 0, 0, 0);
        do_move(0, 0, 1, 0, 0);
        do_move(0, 1, 0, 0, 0);
        chk("chase_alive", alive, 1);
        chk("chase_hx", head_x, 20);
        chk("chase_hy", head_y, 15);

        // Random play against the model.
        do_reset();
        for (int it = 0; it < 150; it++) begin
            logic [3:0] r;
            int         k;
            r = 4'($urandom_range(0, 15));
            do_move(r[3], r[2], r[1], r[0], $urandom_range(0, 2) == 0);
            k = $urandom_range(0, q_x.size() - 1);
            chk_pix(q_x[k] * 16 + $urandom_range(0, 15), q_y[k] * 16 + $urandom_range(0, 15), 1);
            chk_pix($urandom_range(0, 799), $urandom_range(0, 524), $urandom_range(0, 4) != 0);
            if (!m_alive) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snake_field_renderer.md
# snake_field_renderer

Parametrised grid-based snake engine and pixel renderer. It replaces the fixed single-rectangle overlay in the top level. It keeps the snake body in a circular coordinate buffer plus a cell-occupancy bitmap, advances the snake one cell per game `step`, and grows it on `grow`. It detects wall and self collisions, and produces a registered 3-bit colour for the VGA controller's current `pix_x`/`pix_y`.

## Interface
Parameters:
- `CELL_LOG2`, 4: cell size is 2^CELL_LOG2 pixels square.
- `GRID_W`, 40: grid width in cells.
- `GRID_H`, 30: grid height in cells.
- `MAX_LEN`, 64: maximum snake length in segments.
- `INIT_LEN`, 3: length after reset; must be at least 2 and less than GRID_W/2.
- `BG_RGB`, 3'b101: background colour.
- `WALL_RGB`, 3'b010: wall colour.
- `BODY_RGB`, 3'b110: body colour.
- `HEAD_RGB`, 3'b100: head colour.

Ports:
- `clk`  in  1  system/pixel clock (one clock). Reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `step`  in  1  one-cycle game-tick pulse.
- `up`, `down`, `left`, `right`  in  1 each  direction requests, level-sensitive.
- `grow`  in  1  food strobe, sampled together with `step`.
- `pix_x`, `pix_y`  in  10 each  current pixel coordinates.
- `video_on`  in  1  active-video qualifier.
- `rgb`  out  3  pixel colour, registered.
- `alive`  out  1  low once a collision has occurred.
- `busy`  out  1  a move is in progress.
- `length`  out  clog2(MAX_LEN+1)  current number of segments.
- `head_x`  out  clog2(GRID_W)  head cell column.
- `head_y`  out  clog2(GRID_H)  head cell row.

## Operation
- **Walls:** cells with x==0, x==GRID_W-1, y==0 or y==GRID_H-1.
- **Reset values:**
  - head at (GRID_W/2, GRID_H/2), heading right;
  - body extends left, so the tail is at (GRID_W/2-INIT_LEN+1, GRID_H/2);
  - `length`=INIT_LEN, `alive`=1, `busy`=0, `rgb`=0, state IDLE;
  - occupancy holds exactly the INIT_LEN body cells.
- **Direction latch:** updated every cycle in IDLE.
  - Priority when several requests are high: up > down > left > right.
  - A request for the exact reverse of the current heading is ignored.
- **State machine:** IDLE → CALC → CHECK → UPDATE → IDLE. CHECK → DEAD on collision. DEAD is left only by `reset`.
  - IDLE: on `step`, latch `grow` and go to CALC.
  - CALC: register next head = head ± 1 in the latched direction.
  - CHECK: collision = next head is a wall cell, OR it is occupied and is not the current tail cell. Entering the tail cell is a collision when the latched grow is effective.
  - UPDATE: push next head into the buffer and set its occupancy bit.
    - If grow is effective: increment `length`.
    - Otherwise: clear the tail's occupancy bit and advance the tail pointer.
    - If set and clear target the same cell (tail chase), set wins.
  - DEAD: no further moves; rendering continues.
- **Grow cap:** grow is effective only if `length` < MAX_LEN. Otherwise it is a normal move.
- **Ignored steps:** `step` in CALC/CHECK/UPDATE/DEAD is dropped, not queued.
- **Render:** cell = (pix_x >> CELL_LOG2, pix_y >> CELL_LOG2). Colour priority:
  1. `video_on`=0 → 0
  2. cell outside the grid → BG_RGB
  3. wall → WALL_RGB
  4. cell == head → HEAD_RGB
  5. occupied → BODY_RGB
  6. otherwise → BG_RGB

## Timing
- `step` sampled high at edge k:
  - `busy` rises after edge k;
  - the CHECK→DEAD/UPDATE decision is registered at edge k+2, and `alive` falls after edge k+2 on collision;
  - `head_x`, `head_y`, `length` and occupancy update at edge k+3;
  - `busy` falls after edge k+3, and the next `step` is accepted from cycle k+4.
- Render latency is 1 cycle: `rgb` after edge n reflects `pix_x`/`pix_y`/`video_on` sampled at edge n. The occupancy read is combinational on the pixel address.
- An occupancy write at edge k+3 is visible to render from edge k+4.
- `reset` asserted mid-move aborts the move and restores all reset values at the next edge.

## Structure
- Package `snake_pkg` holds:
  - the direction enum (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT);
  - the FSM state enum;
  - default colour constants;
  - a cell-coordinate width function.
- Sub-module `snake_occupancy_map`: a GRID_W×GRID_H bit array with:
  - one combinational render read port;
  - one combinational collision read port;
  - one set port and one clear port, with set priority;
  - synchronous reset to the initial body pattern.
- The top block owns the FSM, the circular coordinate buffer (MAX_LEN entries, head/tail pointers wrapping modulo MAX_LEN) and the render register.

## Test plan
- **Reset then idle:** `length`=3, head=(20,15), `alive`=1. Pixel (320,240) with `video_on`=1 → HEAD_RGB one cycle later. Pixel (0,0) → WALL_RGB. `video_on`=0 → 0.
- **One step, right held:** head=(21,15) and `busy`=0 exactly 4 cycles after `step`. The cell at the old tail (18,15) renders BG_RGB.
- **Reversal:** `left` pressed while heading right, then `step` → head=(21,15). Pressing `up` and `left` together → moves up.
- **Grow:** `step` with `grow`=1 → `length`=4 and the tail is unchanged. At `length`=MAX_LEN, `grow` is ignored.
- **Wall death:** repeat steps right until head x=38; the next step → `alive`=0 after the third edge. Further `step` pulses leave head/length unchanged.
- **Self collision and tail chase:** at length 5, perform up, left, down in sequence; the following step into the body → `alive`=0. At length 4 with the same loop, the move into the tail cell is legal and `alive` stays 1.
